// File: rtl/if_id_stage.sv
// if_id_stage: program counter plus IF/ID pipeline register for the 5-stage
// MIPS pipeline. Applies hold / flush / redirect requests from the hazard
// unit and ID-stage branch/jump logic, and keeps saturating stall and flush
// counters for performance debug. Every output is driven straight from a
// register.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pc_keep,
  input  logic             i_IF_ID_keep,
  input  logic             i_IF_ID_flush,
  input  logic             i_branch_final,
  input  logic [31:0]      i_branch_target,
  input  logic [1:0]       i_jump,
  input  logic [31:0]      i_jr_target,
  input  logic [31:0]      i_instruction,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_IF_ID_instruction,
  output logic [31:0]      o_IF_ID_pc_plus4,
  output logic             o_IF_ID_valid,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0]      PC_INIT   = PC_RESET & WORD_MASK;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] JUMP_J  = 2'b01;
  localparam logic [1:0] JUMP_JR = 2'b10;

  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_instr;
  logic [31:0]      r_ifid_pc4;
  logic             r_ifid_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_tgt;
  logic [31:0]      w_jr_tgt;
  logic [31:0]      w_j_tgt;
  logic [31:0]      w_pc_next;
  logic             w_flush_take;

  // Sequential fetch address wraps naturally modulo 2^32.
  assign w_pc_plus4   = r_pc + 32'd4;
  // Low two bits of every redirect target are forced to zero so o_pc stays word aligned.
  assign w_branch_tgt = i_branch_target & WORD_MASK;
  assign w_jr_tgt     = i_jr_target & WORD_MASK;
  // j/jal target comes from the instruction currently sitting in ID.
  assign w_j_tgt      = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
  // A flush only inserts a bubble when IF/ID is not being held.
  assign w_flush_take = i_IF_ID_flush & ~i_IF_ID_keep;

  // Next-PC select: a held PC suppresses every redirect, so a stalled
  // branch/jump simply re-requests once the stall clears.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (i_pc_keep) begin
      w_pc_next = r_pc;
    end else if (i_branch_final) begin
      w_pc_next = w_branch_tgt;
    end else if (i_jump == JUMP_JR) begin
      w_pc_next = w_jr_tgt;
    end else if (i_jump == JUMP_J) begin
      w_pc_next = w_j_tgt;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PC_INIT;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID register: keep has priority over flush so a held instruction is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_valid <= 1'b0;
    end else if (i_IF_ID_keep) begin
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc4   <= r_ifid_pc4;
      r_ifid_valid <= r_ifid_valid;
    end else if (i_IF_ID_flush) begin
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_valid <= 1'b0;
    end else begin
      r_ifid_instr <= i_instruction;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_valid <= 1'b1;
    end
  end

  // Stall counter: counts cycles with the PC held, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (i_pc_keep && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  // Flush counter: counts bubbles actually inserted, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (w_flush_take && (r_flush_cnt != CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign o_pc                = r_pc;
  assign o_IF_ID_instruction = r_ifid_instr;
  assign o_IF_ID_pc_plus4    = r_ifid_pc4;
  assign o_IF_ID_valid       = r_ifid_valid;
  assign o_stall_count       = r_stall_cnt;
  assign o_flush_count       = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a vector table of per-cycle inputs and expected
// post-edge outputs, fed through a scoreboard queue. A second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_keep = 1'b0;
  logic        ifid_keep = 1'b0;
  logic        ifid_flush = 1'b0;
  logic        branch_final = 1'b0;
  logic [31:0] branch_target = '0;
  logic [1:0]  jump = '0;
  logic [31:0] jr_target = '0;
  logic        ov_en = 1'b0;
  logic [31:0] instr;

  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] pc2, ifid_instr2, ifid_pc42;
  logic        ifid_valid2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instruction memory model: imem[k] = k+1, with an optional j-instruction override.
  assign instr = ov_en ? 32'h0800_0040 : ((pc >> 2) + 32'd1);

  if_id_stage dut (
    .clk(clk), .reset(reset), .i_pc_keep(pc_keep), .i_IF_ID_keep(ifid_keep),
    .i_IF_ID_flush(ifid_flush), .i_branch_final(branch_final),
    .i_branch_target(branch_target), .i_jump(jump), .i_jr_target(jr_target),
    .i_instruction(instr), .o_pc(pc), .o_IF_ID_instruction(ifid_instr),
    .o_IF_ID_pc_plus4(ifid_pc4), .o_IF_ID_valid(ifid_valid),
    .o_stall_count(stall_cnt), .o_flush_count(flush_cnt)
  );

  if_id_stage #(.PC_RESET(32'h0000_0000), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .i_pc_keep(pc_keep), .i_IF_ID_keep(ifid_keep),
    .i_IF_ID_flush(ifid_flush), .i_branch_final(branch_final),
    .i_branch_target(branch_target), .i_jump(jump), .i_jr_target(jr_target),
    .i_instruction(instr), .o_pc(pc2), .o_IF_ID_instruction(ifid_instr2),
    .o_IF_ID_pc_plus4(ifid_pc42), .o_IF_ID_valid(ifid_valid2),
    .o_stall_count(stall_cnt2), .o_flush_count(flush_cnt2)
  );

  typedef struct {
    logic        rst, pk, ik, fl, br, ov;
    logic [31:0] bt;
    logic [1:0]  jp;
    logic [31:0] jt;
    logic [31:0] e_pc, e_ins, e_p4;
    logic        e_v;
    logic [15:0] e_st, e_fl;
  } vec_t;

  typedef struct {
    logic [31:0] e_pc, e_ins, e_p4;
    logic        e_v;
    logic [15:0] e_st, e_fl;
    logic [1:0]  e_st2, e_fl2;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[25];

  function automatic vec_t mk(logic rst, logic pk, logic ik, logic fl, logic br,
                              logic [31:0] bt, logic [1:0] jp, logic [31:0] jt, logic ov,
                              logic [31:0] e_pc, logic [31:0] e_ins, logic [31:0] e_p4,
                              logic e_v, logic [15:0] e_st, logic [15:0] e_fl);
    vec_t v;
    v.rst = rst; v.pk = pk; v.ik = ik; v.fl = fl; v.br = br; v.bt = bt;
    v.jp = jp; v.jt = jt; v.ov = ov;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_p4 = e_p4; v.e_v = e_v;
    v.e_st = e_st; v.e_fl = e_fl;
    return v;
  endfunction

  function automatic logic [1:0] sat2(logic [15:0] x);
    return (x > 16'd3) ? 2'd3 : x[1:0];
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then compare after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset = v.rst; pc_keep = v.pk; ifid_keep = v.ik; ifid_flush = v.fl;
    branch_final = v.br; branch_target = v.bt; jump = v.jp; jr_target = v.jt;
    ov_en = v.ov;
    e.e_pc = v.e_pc; e.e_ins = v.e_ins; e.e_p4 = v.e_p4; e.e_v = v.e_v;
    e.e_st = v.e_st; e.e_fl = v.e_fl; e.e_st2 = sat2(v.e_st); e.e_fl2 = sat2(v.e_fl);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard step %0d: queue empty, expected 1 entry", idx);
    end else begin
      g = sb.pop_front();
      chk("o_pc", idx, pc, g.e_pc);
      chk("ifid_instr", idx, ifid_instr, g.e_ins);
      chk("ifid_pc4", idx, ifid_pc4, g.e_p4);
      chk("ifid_valid", idx, {31'd0, ifid_valid}, {31'd0, g.e_v});
      chk("stall_cnt", idx, {16'd0, stall_cnt}, {16'd0, g.e_st});
      chk("flush_cnt", idx, {16'd0, flush_cnt}, {16'd0, g.e_fl});
      chk("stall_cnt_w2", idx, {30'd0, stall_cnt2}, {30'd0, g.e_st2});
      chk("flush_cnt_w2", idx, {30'd0, flush_cnt2}, {30'd0, g.e_fl2});
      $display("step %0d: pc=0x%08h ins=0x%08h p4=0x%08h v=%0b st=%0d fl=%0d st2=%0d fl2=%0d",
               idx, pc, ifid_instr, ifid_pc4, ifid_valid, stall_cnt, flush_cnt,
               stall_cnt2, flush_cnt2);
    end
  endtask

  initial begin
    //               rst pk ik fl br bt            jp     jt            ov  e_pc          e_ins         e_p4          v  st  fl
    vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h4,        32'h1,        32'h4,        1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h8,        32'h2,        32'h8,        1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'hC,        32'h3,        32'hC,        1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h10,       32'h4,        32'h10,       1, 0, 0);
    vecs[6]  = mk(0, 1, 1, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h10,       32'h4,        32'h10,       1, 1, 0);
    vecs[7]  = mk(0, 1, 1, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h10,       32'h4,        32'h10,       1, 2, 0);
    vecs[8]  = mk(0, 0, 0, 1, 1, 32'h101,      2'b00, 32'h0,        0, 32'h100,      32'h0,        32'h0,        0, 2, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h104,      32'h41,       32'h104,      1, 2, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        1, 32'h108,      32'h0800_0040,32'h108,      1, 2, 1);
    vecs[11] = mk(0, 0, 0, 1, 0, 32'h0,        2'b01, 32'h0,        0, 32'h100,      32'h0,        32'h0,        0, 2, 2);
    vecs[12] = mk(0, 0, 0, 1, 0, 32'h0,        2'b10, 32'h203,      0, 32'h200,      32'h0,        32'h0,        0, 2, 3);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h204,      32'h81,       32'h204,      1, 2, 3);
    vecs[14] = mk(0, 1, 1, 1, 0, 32'h0,        2'b10, 32'h303,      0, 32'h204,      32'h81,       32'h204,      1, 3, 3);
    vecs[15] = mk(0, 0, 0, 1, 0, 32'h0,        2'b10, 32'h303,      0, 32'h300,      32'h0,        32'h0,        0, 3, 4);
    vecs[16] = mk(0, 0, 0, 1, 1, 32'h400,      2'b10, 32'h500,      0, 32'h400,      32'h0,        32'h0,        0, 3, 5);
    vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,        2'b11, 32'h900,      0, 32'h404,      32'h101,      32'h404,      1, 3, 5);
    vecs[18] = mk(0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h404,      32'h102,      32'h408,      1, 4, 5);
    vecs[19] = mk(0, 0, 1, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h408,      32'h102,      32'h408,      1, 4, 5);
    vecs[20] = mk(0, 0, 0, 1, 0, 32'h0,        2'b00, 32'h0,        0, 32'h40C,      32'h0,        32'h0,        0, 4, 6);
    vecs[21] = mk(0, 0, 0, 1, 1, 32'hFFFF_FFFF,2'b00, 32'h0,        0, 32'hFFFF_FFFC,32'h0,        32'h0,        0, 4, 7);
    vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h0,        32'h4000_0000,32'h0,        1, 4, 7);
    vecs[23] = mk(1, 1, 1, 1, 0, 32'h0,        2'b10, 32'h700,      0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h4,        32'h1,        32'h4,        1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run_vec(vecs[i], i);
    end

    // Long stall: the 2-bit counter sticks at 3 while the 16-bit one keeps counting.
    for (int k = 1; k <= 5; k++) begin
      run_vec(mk(0, 1, 1, 0, 0, 32'h0, 2'b00, 32'h0, 0,
                 32'h4, 32'h1, 32'h4, 1, 16'(k), 16'd0), 24 + k);
    end

    // Reset in the middle of a stall with a pending jr discards everything.
    run_vec(mk(1, 1, 1, 0, 0, 32'h0, 2'b10, 32'h800, 0,
               32'h0, 32'h0, 32'h0, 0, 16'd0, 16'd0), 30);

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
